wb_result_drain: RTL



---
 rtl/wb_result_drain.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/wb_result_drain.sv
// wb_result_drain: captures a 4-entry execute result bundle and drains it in order onto reg/seg/mem write ports (optional perf counters: WB_PERF_CNT_EN)
module wb_result_drain #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] res1,
    input  logic [DATA_W-1:0] res2,
    input  logic [DATA_W-1:0] res3,
    input  logic [DATA_W-1:0] res4,
    input  logic              res1_wb,
    input  logic              res2_wb,
    input  logic              res3_wb,
    input  logic              res4_wb,
    input  logic              res1_is_reg,
    input  logic              res2_is_reg,
    input  logic              res3_is_reg,
    input  logic              res4_is_reg,
    input  logic              res1_is_seg,
    input  logic              res2_is_seg,
    input  logic              res3_is_seg,
    input  logic              res4_is_seg,
    input  logic              res1_is_mem,
    input  logic              res2_is_mem,
    input  logic              res3_is_mem,
    input  logic              res4_is_mem,
    input  logic [ADDR_W-1:0] res1_dest,
    input  logic [ADDR_W-1:0] res2_dest,
    input  logic [ADDR_W-1:0] res3_dest,
    input  logic [ADDR_W-1:0] res4_dest,
    input  logic [1:0]        ressize,
    input  logic              mem_wr_ready,
    output logic              stall_out,
    output logic              reg_wr_en,
    output logic [2:0]        reg_wr_idx,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic [1:0]        reg_wr_size,
    output logic              seg_wr_en,
    output logic [2:0]        seg_wr_idx,
    output logic [15:0]       seg_wr_data,
    output logic              mem_wr_valid,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [1:0]        mem_wr_size,
    output logic              bundle_done
`ifdef WB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  mem_stall_cnt
`endif
);
    typedef enum logic {IDLE, DRAIN} state_t;
    localparam logic [1:0] CLS_REG = 2'd0;
    localparam logic [1:0] CLS_SEG = 2'd1;
    localparam logic [1:0] CLS_MEM = 2'd2;
    state_t                   state_q, state_d;
    logic [3:0]               pend_q, pend_d;
    logic [3:0][DATA_W-1:0]   data_q, data_d;
    logic [3:0][ADDR_W-1:0]   dest_q, dest_d;
    logic [3:0][1:0]          cls_q, cls_d;
    logic [1:0]               size_q, size_d;
    logic                     done_q, done_d;
    logic [3:0][DATA_W-1:0]   res_in;
    logic [3:0][ADDR_W-1:0]   dest_in;
    logic [3:0]               wb_in, reg_in, seg_in, mem_in, pend_in;
    logic [3:0][1:0]          cls_in;
    logic [1:0]               sel, sel_cls;
    logic [3:0]               pend_left;
    logic                     drain, complete, last, cap;

    assign res_in  = {res4, res3, res2, res1};
    assign dest_in = {res4_dest, res3_dest, res2_dest, res1_dest};
    assign wb_in   = {res4_wb, res3_wb, res2_wb, res1_wb};
    assign reg_in  = {res4_is_reg, res3_is_reg, res2_is_reg, res1_is_reg};
    assign seg_in  = {res4_is_seg, res3_is_seg, res2_is_seg, res1_is_seg};
    assign mem_in  = {res4_is_mem, res3_is_mem, res2_is_mem, res1_is_mem};

    // decode each incoming entry into a pending bit and a single class (mem > seg > reg)
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pend_in[i] = wb_in[i] & (reg_in[i] | seg_in[i] | mem_in[i]);
            cls_in[i]  = mem_in[i] ? CLS_MEM : seg_in[i] ? CLS_SEG : CLS_REG;
        end
    end

    // pick the lowest pending entry and work out whether the bundle finishes this cycle
    always_comb begin
        drain     = state_q == DRAIN;
        sel       = pend_q[0] ? 2'd0 : pend_q[1] ? 2'd1 : pend_q[2] ? 2'd2 : 2'd3;
        sel_cls   = cls_q[sel];
        complete  = drain & ((sel_cls != CLS_MEM) | mem_wr_ready);
        pend_left = pend_q & ~(4'b0001 << sel);
        last      = complete & ~|pend_left;
        stall_out = drain & ~last;
        cap       = valid_in & ~stall_out;
    end

    // write ports driven purely from registered state; payloads are zero when not strobing
    always_comb begin
        reg_wr_en    = drain & (sel_cls == CLS_REG);
        seg_wr_en    = drain & (sel_cls == CLS_SEG);
        mem_wr_valid = drain & (sel_cls == CLS_MEM);
        reg_wr_idx   = reg_wr_en ? dest_q[sel][2:0] : 3'd0;
        reg_wr_data  = reg_wr_en ? data_q[sel] : '0;
        reg_wr_size  = reg_wr_en ? size_q : 2'd0;
        seg_wr_idx   = seg_wr_en ? dest_q[sel][2:0] : 3'd0;
        seg_wr_data  = seg_wr_en ? data_q[sel][15:0] : 16'd0;
        mem_wr_addr  = mem_wr_valid ? dest_q[sel] : '0;
        mem_wr_data  = mem_wr_valid ? data_q[sel] : '0;
        mem_wr_size  = mem_wr_valid ? size_q : 2'd0;
        bundle_done  = done_q;
    end

    // retire completed entries, then capture a new bundle once the old one is on its last write
    always_comb begin
        state_d = state_q;
        pend_d  = complete ? pend_left : pend_q;
        data_d  = data_q;
        dest_d  = dest_q;
        cls_d   = cls_q;
        size_d  = size_q;
        done_d  = last | (cap & ~|pend_in);
        if (last)
            state_d = IDLE;
        if (cap & |pend_in) begin
            state_d = DRAIN;
            pend_d  = pend_in;
            data_d  = res_in;
            dest_d  = dest_in;
            cls_d   = cls_in;
            size_d  = ressize;
        end
    end

    // state registers; reset discards any partially drained bundle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            data_q  <= '0;
            dest_q  <= '0;
            cls_q   <= '0;
            size_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
            cls_q   <= cls_d;
            size_q  <= size_d;
            done_q  <= done_d;
        end
    end

`ifdef WB_PERF_CNT_EN
    logic [CNT_W-1:0] retire_q, retire_d, mstall_q, mstall_d;

    // free-running wrapping counters of retired bundles and memory stall cycles
    always_comb begin
        retire_d = retire_q + {{(CNT_W-1){1'b0}}, done_q};
        mstall_d = mstall_q + {{(CNT_W-1){1'b0}}, mem_wr_valid & ~mem_wr_ready};
    end

    // counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q <= '0;
            mstall_q <= '0;
        end else begin
            retire_q <= retire_d;
            mstall_q <= mstall_d;
        end
    end

    assign retire_cnt    = retire_q;
    assign mem_stall_cnt = mstall_q;
`endif
endmodule
